// File: rtl/drop_resolver.sv
// drop_resolver
//   Resolves a player's drop of the moving block against the tower's top block.
//   It starts a new game, samples the moving block's x when the player drops it,
//   trims the block to its overlap with the tower and stores the result as the
//   new top block. It then relaunches the next block through the x register's
//   load interface. A complete miss ends the game.
//
// Ports
//   clk            system clock
//   resetn         synchronous active-low reset
//   start          new-game pulse (accepted in IDLE and OVER only)
//   drop           player drop pulse (accepted in READY only)
//   curr_x         live x of the moving block
//   load_x         one-cycle load strobe to the x register
//   new_x_position spawn x for the x register
//   new_direction  spawn direction, 1 = right, 0 = left
//   top_x          left edge of the tower's top block
//   top_width      width of the top block (and of the moving block)
//   score          blocks stacked, saturating at 255
//   perfect        last drop snapped onto the top block
//   busy           a drop is being resolved
//   game_over      the last drop missed
module drop_resolver #(
  parameter int unsigned X_MAX      = 144,
  parameter int unsigned INIT_X     = 72,
  parameter int unsigned INIT_WIDTH = 16,
  parameter int unsigned SNAP_TOL   = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       drop,
  input  logic [7:0] curr_x,
  output logic       load_x,
  output logic [7:0] new_x_position,
  output logic       new_direction,
  output logic [7:0] top_x,
  output logic [7:0] top_width,
  output logic [7:0] score,
  output logic       perfect,
  output logic       busy,
  output logic       game_over
);

  localparam logic [7:0] L_X_MAX  = 8'(X_MAX);
  localparam logic [7:0] L_INIT_X = 8'(INIT_X);
  localparam logic [7:0] L_INIT_W = 8'(INIT_WIDTH);
  localparam logic [8:0] L_SNAP   = 9'(SNAP_TOL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_READY,
    S_CALC,
    S_COMMIT,
    S_OVER
  } state_t;

  state_t     r_state, w_state_n;

  logic [7:0] r_top_x,   w_top_x_n;
  logic [7:0] r_top_w,   w_top_w_n;
  logic [7:0] r_score,   w_score_n;
  logic       r_perfect, w_perfect_n;
  logic       r_busy,    w_busy_n;
  logic       r_over,    w_over_n;
  logic       r_load,    w_load_n;
  logic [7:0] r_new_x,   w_new_x_n;
  logic       r_new_dir, w_new_dir_n;
  logic [7:0] r_cx,      w_cx_n;
  logic [7:0] r_left,    w_left_n;
  logic [7:0] r_width,   w_width_n;

  // Overlap arithmetic, evaluated in CALC. Everything is 9 bits wide so that
  // right edges up to 255+255 do not wrap.
  logic [8:0] w_cx9, w_tx9, w_w9;
  logic [8:0] w_dx;
  logic       w_snap;
  logic [8:0] w_cxs;
  logic [8:0] w_left;
  logic [8:0] w_rt_a, w_rt_b, w_right;
  logic       w_hit;
  logic [7:0] w_width;
  logic [7:0] w_score_inc;

  always_comb begin
    w_cx9   = {1'b0, r_cx};
    w_tx9   = {1'b0, r_top_x};
    w_w9    = {1'b0, r_top_w};
    w_dx    = (w_cx9 >= w_tx9) ? (w_cx9 - w_tx9) : (w_tx9 - w_cx9);
    w_snap  = (w_dx <= L_SNAP);
    w_cxs   = w_snap ? w_tx9 : w_cx9;
    w_left  = (w_cxs > w_tx9) ? w_cxs : w_tx9;
    w_rt_a  = w_cxs + w_w9;
    w_rt_b  = w_tx9 + w_w9;
    w_right = (w_rt_a < w_rt_b) ? w_rt_a : w_rt_b;
    w_hit   = (w_right > w_left);
    // On a hit the width is at most top_width, so 8-bit modular subtraction
    // of the low bytes gives the exact value.
    w_width = w_right[7:0] - w_left[7:0];
    w_score_inc = (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_top_x   <= L_INIT_X;
      r_top_w   <= L_INIT_W;
      r_score   <= '0;
      r_perfect <= 1'b0;
      r_busy    <= 1'b0;
      r_over    <= 1'b0;
      r_load    <= 1'b0;
      r_new_x   <= '0;
      r_new_dir <= 1'b1;
      r_cx      <= '0;
      r_left    <= '0;
      r_width   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_top_x   <= w_top_x_n;
      r_top_w   <= w_top_w_n;
      r_score   <= w_score_n;
      r_perfect <= w_perfect_n;
      r_busy    <= w_busy_n;
      r_over    <= w_over_n;
      r_load    <= w_load_n;
      r_new_x   <= w_new_x_n;
      r_new_dir <= w_new_dir_n;
      r_cx      <= w_cx_n;
      r_left    <= w_left_n;
      r_width   <= w_width_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_top_x_n   = r_top_x;
    w_top_w_n   = r_top_w;
    w_score_n   = r_score;
    w_perfect_n = r_perfect;
    w_busy_n    = r_busy;
    w_over_n    = r_over;
    w_load_n    = 1'b0;
    w_new_x_n   = r_new_x;
    w_new_dir_n = r_new_dir;
    w_cx_n      = r_cx;
    w_left_n    = r_left;
    w_width_n   = r_width;

    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_state_n   = S_SPAWN;
          w_top_x_n   = L_INIT_X;
          w_top_w_n   = L_INIT_W;
          w_score_n   = '0;
          w_perfect_n = 1'b0;
          w_over_n    = 1'b0;
          w_busy_n    = 1'b0;
          w_load_n    = 1'b1;
          w_new_x_n   = '0;
          w_new_dir_n = 1'b1;
        end
      end
      S_SPAWN: begin
        w_state_n = S_READY;
        w_busy_n  = 1'b0;
      end
      S_READY: begin
        if (drop) begin
          w_state_n = S_CALC;
          w_cx_n    = curr_x;
          w_busy_n  = 1'b1;
        end
      end
      S_CALC: begin
        w_perfect_n = w_snap;
        w_left_n    = w_left[7:0];
        w_width_n   = w_width;
        if (w_hit) begin
          w_state_n = S_COMMIT;
        end else begin
          w_state_n = S_OVER;
          w_over_n  = 1'b1;
          w_busy_n  = 1'b0;
        end
      end
      S_COMMIT: begin
        w_state_n   = S_SPAWN;
        w_top_x_n   = r_left;
        w_top_w_n   = r_width;
        w_score_n   = w_score_inc;
        w_load_n    = 1'b1;
        // Spawn side follows the parity of the updated score.
        w_new_x_n   = w_score_inc[0] ? L_X_MAX : 8'd0;
        w_new_dir_n = ~w_score_inc[0];
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign load_x         = r_load;
  assign new_x_position = r_new_x;
  assign new_direction  = r_new_dir;
  assign top_x          = r_top_x;
  assign top_width      = r_top_w;
  assign score          = r_score;
  assign perfect        = r_perfect;
  assign busy           = r_busy;
  assign game_over      = r_over;

endmodule
